// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-side responders (data memory now,
// instruction memory later): FSM encoding, word and wait-counter widths.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mips_word_array.sv
// Word-addressed storage: synchronous write, combinational read, cleared by
// reset, with the low half of word 0 tapped out for observation.
module mips_word_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata,
    output logic [15:0]           word0_lo
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata    = mem[idx];
    assign word0_lo = mem[0][15:0];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core: one request at a time, a fixed
// number of wait states, then a response held until the core takes it.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [15:0]       test_value
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);
    localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);

    // Misaligned, or beyond the last stored word.
    function automatic logic addr_bad(input logic [WORD_W-1:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != '0);
    endfunction

    state_t                  state;
    logic [WAIT_W-1:0]       wait_cnt;
    mem_req_t                lat_req;
    mem_req_t                cur_req;
    logic                    handshake;
    logic                    commit;
    logic                    commit_err;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic [WORD_W-1:0]       rd_word;

    assign handshake = (state == ST_IDLE) && req_valid && req_ready;

    // With no wait states the access commits in the accept cycle, so it must
    // use the live request rather than the latched copy.
    always_comb begin
        cur_req = lat_req;
        if (ZERO_WAIT) begin
            cur_req = {req_we, req_addr, req_wdata};
        end
    end

    assign commit     = ZERO_WAIT ? handshake
                                  : ((state == ST_BUSY) && (wait_cnt == WAIT_LAST));
    assign commit_err = addr_bad(cur_req.addr);
    assign word_idx   = cur_req.addr[DEPTH_LOG2+1:2];
    assign mem_we     = commit && cur_req.we && !commit_err;

    mips_word_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .we       (mem_we),
        .idx      (word_idx),
        .wdata    (cur_req.wdata),
        .rdata    (rd_word),
        .word0_lo (test_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (handshake) begin
                        lat_req   <= {req_we, req_addr, req_wdata};
                        req_ready <= 1'b0;
                        if (ZERO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_BUSY;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    wait_cnt <= wait_cnt - WAIT_LAST;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                end
            endcase

            // Response is captured from the same cycle the access commits.
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= commit_err;
                rsp_rdata <= (commit_err || cur_req.we) ? '0 : rd_word;
            end
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven in lockstep
// against a plain array model of the data memory.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        rr_rand = 1'b0;

    logic        rdy  [2];
    logic        rv   [2];
    logic        rerr [2];
    logic [31:0] rdat [2];
    logic [15:0] tv   [2];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] tv;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem_m [64];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdat[0]),
        .rsp_err(rerr[0]), .test_value(tv[0])
    );

    mips_dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdat[1]),
        .rsp_err(rerr[1]), .test_value(tv[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every accepted response against the scoreboard and
    // checks latency and hold-while-stalled behaviour.
    logic        pv   [2] = '{1'b0, 1'b0};
    logic [31:0] pdat [2];
    logic        perr [2];
    logic        prr = 1'b0;
    int          acc  [2] = '{0, 0};

    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            pv[0] <= 1'b0;
            pv[1] <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                automatic exp_t e;
                automatic logic have = 1'b0;
                if (req_valid && rdy[d]) acc[d] <= cyc;
                if (pv[d] && !prr) begin
                    chk($sformatf("hold_valid[%0d]", d), 32'(rv[d]), 32'd1);
                    chk($sformatf("hold_rdata[%0d]", d), rdat[d], pdat[d]);
                    chk($sformatf("hold_err[%0d]", d), 32'(rerr[d]), 32'(perr[d]));
                end
                if (rv[d] && !pv[d]) begin
                    chk($sformatf("latency[%0d]", d), 32'(cyc - acc[d]), (d == 0) ? 32'd3 : 32'd1);
                    if (d == 0) have = (q0.size() != 0); else have = (q1.size() != 0);
                    if (have) begin
                        e = (d == 0) ? q0[0] : q1[0];
                        chk($sformatf("test_value_at_rsp[%0d]", d), 32'(tv[d]), 32'(e.tv));
                    end
                end
                if (rv[d] && rsp_ready) begin
                    if (d == 0) have = (q0.size() != 0); else have = (q1.size() != 0);
                    chk($sformatf("rsp_expected[%0d]", d), 32'(have), 32'd1);
                    if (have) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rsp_rdata[%0d]", d), rdat[d], e.rdata);
                        chk($sformatf("rsp_err[%0d]", d), 32'(rerr[d]), 32'(e.err));
                    end
                end
                pv[d]   <= rv[d];
                pdat[d] <= rdat[d];
                perr[d] <= rerr[d];
            end
        end
        prr <= rsp_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int   n = 0;
        exp_t e;
        logic bad;
        while (!(rdy[0] && rdy[1]) && n < 200) begin
            tick();
            n++;
        end
        chk("issue_wait", 32'(rdy[0] && rdy[1]), 32'd1);
        if (!(rdy[0] && rdy[1])) return;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        bad     = (addr % 4 != 0) || (addr >= 32'd256);
        e.err   = bad;
        e.rdata = (bad || we) ? 32'd0 : mem_m[addr / 4];
        if (!bad && we) mem_m[addr / 4] = wd;
        e.tv    = mem_m[0][15:0];
        q0.push_back(e);
        q1.push_back(e);
        tick();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rdy[0] && rdy[1] && q0.size() == 0 && q1.size() == 0) && n < 300) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(rdy[0] && rdy[1]), 32'd1);
        chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic chk_tv();
        for (int d = 0; d < 2; d++)
            chk($sformatf("test_value[%0d]", d), 32'(tv[d]), 32'(mem_m[0][15:0]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem_m[i] = '0;

        // Reset held two cycles, then release.
        reset = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req_ready[%0d]", d), 32'(rdy[d]), 32'd0);
            chk($sformatf("rst_rsp_valid[%0d]", d), 32'(rv[d]), 32'd0);
        end
        reset = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_rst_req_ready[%0d]", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("post_rst_rsp_valid[%0d]", d), 32'(rv[d]), 32'd0);
            chk($sformatf("post_rst_rdata[%0d]", d), rdat[d], 32'd0);
            chk($sformatf("post_rst_err[%0d]", d), 32'(rerr[d]), 32'd0);
        end
        chk_tv();

        // Store then load back; word-0 store shows on test_value.
        rsp_ready = 1'b1;
        issue(1'b1, 32'h4, 32'hDEAD_BEEF);
        issue(1'b0, 32'h4, 32'h0);
        issue(1'b1, 32'h0, 32'h0000_1234);
        wait_idle();
        chk_tv();

        // Misaligned and out-of-range accesses; errant store must not land.
        issue(1'b0, 32'h6, 32'h0);
        issue(1'b0, 32'h100, 32'h0);
        issue(1'b1, 32'h100, 32'hFFFF_FFFF);
        issue(1'b1, 32'h2, 32'hFFFF_FFFF);
        issue(1'b0, 32'h0, 32'h0);
        issue(1'b0, 32'h4, 32'h0);
        wait_idle();
        chk_tv();

        // Back-pressure: response held, new request ignored while stalled.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h4, 32'h0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h8;
        req_wdata = 32'h5555_5555;
        repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("stall_req_ready[%0d]", d), 32'(rdy[d]), 32'd0);
                chk($sformatf("stall_rsp_valid[%0d]", d), 32'(rv[d]), 32'd1);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("release_req_ready[%0d]", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("release_rsp_valid[%0d]", d), 32'(rv[d]), 32'd0);
        end
        issue(1'b0, 32'h8, 32'h0);
        wait_idle();

        // Reset while the store is still waiting: nothing survives.
        issue(1'b1, 32'h14, 32'hCAFE_F00D);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++)
            chk($sformatf("abort_rsp_valid[%0d]", d), 32'(rv[d]), 32'd0);
        chk_tv();
        tick();
        issue(1'b0, 32'h14, 32'h0);
        issue(1'b0, 32'h4, 32'h0);
        wait_idle();

        // Randomized traffic with random back-pressure.
        rr_rand = 1'b1;
        for (int t = 0; t < 80; t++) begin
            automatic int          kind = $urandom_range(0, 9);
            automatic logic [31:0] a;
            if (kind < 8)       a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            else if (kind == 8) a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
            else                a = $urandom | 32'h100;
            if (t % 16 == 0) a = 32'h0;
            issue(1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();
        rr_rand = 1'b0;
        rsp_ready = 1'b1;
        chk_tv();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
